// File: rtl/unload_loc_mem_fsm_pkg.sv
// Shared types and helpers for the local-memory unload FSM: state encoding
// and the ceil-log2 used to size the RAM address.
package unload_loc_mem_fsm_pkg;

    typedef enum logic [2:0] {
        S_START = 3'b000,
        S_READ  = 3'b001,
        S_WAIT  = 3'b010,
        S_WRITE = 3'b011,
        S_END   = 3'b100
    } state_t;

    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // A one-entry RAM still needs a one-bit address port.
    function automatic int addr_width(input int depth);
        return (log2(depth) < 1) ? 1 : log2(depth);
    endfunction

endpackage

// File: rtl/unload_loc_mem_fsm_if.sv
// Bundle of parent handshake, RAM read port and output FIFO write port
// seen by the unload FSM.
interface unload_loc_mem_fsm_if
    import unload_loc_mem_fsm_pkg::*;
#(
    parameter int size  = 3,
    parameter int width = 10
);
    localparam int aw = addr_width(size);

    logic             start_in;
    logic [width-1:0] length_in;
    logic [width-1:0] ram_data_in;
    logic             fifo_full_in;
    logic             rd_en;
    logic [aw-1:0]    rd_addr;
    logic             wr_out_fifo;
    logic [width-1:0] data_out;
    logic             done_out;

    modport master (
        output start_in, length_in, ram_data_in, fifo_full_in,
        input  rd_en, rd_addr, wr_out_fifo, data_out, done_out
    );

    modport slave (
        input  start_in, length_in, ram_data_in, fifo_full_in,
        output rd_en, rd_addr, wr_out_fifo, data_out, done_out
    );

endinterface

// File: rtl/unload_loc_mem_fsm.sv
// Drains up to size tokens from the actor's local RAM into the output FIFO,
// one read per token, stalling in S_WRITE while the FIFO is full.
module unload_loc_mem_fsm
    import unload_loc_mem_fsm_pkg::*;
#(
    parameter int size  = 3,
    parameter int width = 10
) (
    input logic                clk,
    input logic                rst,
    unload_loc_mem_fsm_if.slave bus
);
    localparam int aw = addr_width(size);

    state_t           state, state_nxt;
    logic [aw:0]      count, count_nxt;
    logic [aw:0]      addr, addr_nxt;
    logic [aw:0]      addr_inc;
    logic [aw:0]      len_clamped;
    logic [width-1:0] hold, hold_nxt;

    assign addr_inc    = addr + 1'b1;
    assign len_clamped = (int'(bus.length_in) > size) ? (aw + 1)'(size)
                                                      : bus.length_in[aw:0];

    // The FIFO only ever sees the hold register; wr_out_fifo qualifies it.
    assign bus.data_out = hold;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values computed by the combinational process.
        if (!rst) begin
            state <= S_START;
            count <= '0;
            addr  <= '0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            addr  <= addr_nxt;
            hold  <= hold_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_nxt       = state;
        count_nxt       = count;
        addr_nxt        = addr;
        hold_nxt        = hold;
        bus.rd_en       = 1'b0;
        bus.rd_addr     = '0;
        bus.wr_out_fifo = 1'b0;
        bus.done_out    = 1'b0;

        case (state)
            S_START: begin
                if (bus.start_in) begin
                    count_nxt = len_clamped;
                    addr_nxt  = '0;
                    state_nxt = (len_clamped == '0) ? S_END : S_READ;
                end
            end
            S_READ: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = addr[aw-1:0];
                state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                hold_nxt  = bus.ram_data_in;
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                // Backpressure is honoured in the same cycle; no new read is
                // issued until this token has been accepted.
                bus.wr_out_fifo = !bus.fifo_full_in;
                if (!bus.fifo_full_in) begin
                    addr_nxt  = addr_inc;
                    state_nxt = (addr_inc == count) ? S_END : S_READ;
                end
            end
            S_END: begin
                bus.done_out = 1'b1;
                state_nxt    = S_START;
            end
            default: begin
                state_nxt = S_START;
            end
        endcase
    end

endmodule

// File: doc/unload_loc_mem_fsm.md
Name: unload_loc_mem_fsm

Overview:
- Level-3 nested FSM that drains N tokens from an actor's local single_port_ram into an output FIFO, one token per ram read.
- It is the write-side counterpart of the local-memory load FSM. The load FSM moves data FIFO -> RAM; this block moves RAM -> FIFO.
- Started by a one-cycle start pulse from a level-2 firing-state FSM. Reports completion with a one-cycle done pulse.
- Used by CFDF modes that emit a vector result, instead of a single scalar write.

Parameters:
- size, 3, depth of the local RAM (maximum token count).
- width, 10, token bit width.
- (derived) aw = log2(size), RAM address width. log2 uses the same ceil-log2 function as the firing FSMs.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- start_in  input  1  one-cycle start pulse from the parent FSM.
- length_in  input  width  number of tokens to unload; sampled only when a start is accepted.
- ram_data_in  input  width  RAM read data, valid the cycle after rd_en.
- fifo_full_in  input  1  output FIFO full flag.
- rd_en  output  1  RAM read enable.
- rd_addr  output  aw  RAM read address.
- wr_out_fifo  output  1  output FIFO write enable.
- data_out  output  width  token presented to the output FIFO.
- done_out  output  1  one-cycle completion pulse to the parent FSM.

Behaviour:
- Reset: synchronous, active-low. rst=0 at a rising edge forces the following:
  - state=S_START, count=0, addr=0, hold register=0.
  - All outputs 0: rd_en, rd_addr, wr_out_fifo, data_out, done_out.
  - A reset asserted mid-operation aborts the transfer with no further writes. A done pulse is not issued.
- States and transitions:
  - S_START: idle; all outputs 0.
    - If start_in=1, latch len = min(length_in, size) and clear addr.
    - If len is 0, go to S_END; otherwise go to S_READ.
    - If start_in=0, stay in S_START.
  - S_READ: rd_en=1, rd_addr=addr. Next state is S_WAIT.
  - S_WAIT: rd_en=0. Capture ram_data_in into the hold register. Next state is S_WRITE.
  - S_WRITE: data_out=hold.
    - wr_out_fifo = !fifo_full_in. This is the only combinational input-to-output path.
    - If fifo_full_in=1, stay in S_WRITE; hold and addr are unchanged.
    - Otherwise addr<=addr+1. If addr+1 equals len, go to S_END; else go to S_READ.
  - S_END: done_out=1 for exactly one cycle, then go to S_START.
- Latency:
  - Start sampled at edge 0.
  - With no stall, token k is written in cycle 3k+3 (k starting at 0).
  - done_out is asserted in cycle 3*len+1.
  - len=0: done_out in cycle 1.
- Each FIFO full cycle adds exactly one cycle of latency.
- A start_in arriving in any state other than S_START is ignored. It is not queued.
- Addresses run 0..len-1 with no wrap-around; addr never exceeds size-1.
- data_out holds its last value outside S_WRITE. It is qualified only by wr_out_fifo.
- The block issues no RAM read while a FIFO write is pending. It therefore never overreads the RAM under backpressure.
- Widths:
  - count/addr comparison is aw+1 bits wide.
  - length_in values greater than size are clamped to size. There is no error flag.

Decomposition:
- Shared package: state localparams (S_START=3'b000, S_READ=3'b001, S_WAIT=3'b010, S_WRITE=3'b011, S_END=3'b100) and the log2 function.
- The MODE_* encodings stay with the firing FSMs.
- No sub-module: a single FSM with an address counter and a hold register.

Test Plan:
- RAM preloaded with 5,7,9; length_in=3; FIFO never full.
  - Writes 5,7,9 in cycles 3,6,9.
  - rd_addr sequence 0,1,2.
  - done_out=1 only in cycle 10.
- length_in=0: no rd_en and no wr_out_fifo; done_out in cycle 1; back in S_START in cycle 2.
- length_in=3; fifo_full_in held high for 4 cycles on token 1 (value 7).
  - wr_out_fifo=0 during the stall and data_out stays 7.
  - The single write of 7 occurs in cycle 10; done_out in cycle 14.
  - No extra rd_en pulses occur during the stall.
- length_in=5 with size=3: exactly 3 writes (addr 0..2); done_out in cycle 10.
- Start, then rst=0 in S_WAIT of token 1:
  - All outputs 0 the next cycle; no done_out.
  - A new start with length_in=1 then writes ram[0] and finishes normally.
- start_in pulsed again in cycle 4 of a len=3 transfer: ignored; exactly one done_out, and total writes equal 3.
